display_formatter: RTL
======================

# display_formatter

Sequential binary-to-display formatter that drives the six-digit seven-segment display stage. It accepts a binary value on a load handshake and converts it to BCD by iterative shift-add-3, one bit per clock. It then applies sign, overflow, leading-zero blanking and decimal-point rules, and updates all display outputs atomically. Its outputs connect directly to the digit, blanking and decimal-point inputs of the seven-segment decoder stage.

## Interface
- WIDTH, 20, binary input width; legal range 4..20.
- SIGNED, 0, 1 = `value` is two's complement; 0 = unsigned.
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- load  input  1  request to convert `value`; accepted only when `ready`=1.
- value  input  WIDTH  binary number to display.
- dp_pos  input  3  decimal-point digit index 0..5; 6 or 7 = no point.
- blank_lz  input  1  1 = blank leading zeros.
- display_en  input  1  0 = blank all six digits.
- ready  output  1  idle; a `load` is accepted this cycle.
- done  output  1  one-cycle pulse when new display outputs become valid.
- overflow  output  1  last accepted value was not displayable.
- Num_Hex0..Num_Hex3  output  4 each  BCD digits 0..3; digit 0 is least significant.
- Num_Hex4, Num_Hex5  output  5 each  digit codes: 0x00–0x0F are hex digits, 0x10 is '-', 0x11 is 'r'.
- Blanked  output  6  bit i = 1 blanks digit i.
- DP_in  output  6  bit i = 1 lights the decimal point of digit i.

## Operation
- The FSM has three states: IDLE, CONVERT and FORMAT.
- IDLE to CONVERT on `load` & `ready`. The block captures the following at that edge:
  - magnitude: |value| when SIGNED=1, otherwise `value`.
  - neg: the sign bit when SIGNED=1, otherwise 0.
  - dp_pos, blank_lz and display_en.
  - ovf, computed as follows:
    - unsigned: magnitude > 999999.
    - signed, neg=1: magnitude > 99999.
    - signed, neg=0: magnitude > 999999.
- CONVERT lasts exactly WIDTH cycles. Each cycle, add 3 to every 4-bit nibble of the 24-bit BCD accumulator that is ≥5, then shift {bcd, mag} left by one. A bit counter counts from WIDTH-1 down to 0.
- When the counter reaches 0, go to FORMAT.
- FORMAT lasts one cycle. At its closing edge, register all display outputs and `overflow`, and set `done`=1. Return to IDLE.
- Formatting rules, applied in this priority order:
  1. display_en=0: Blanked=6'h3F, DP_in=0, digits keep their new values.
  2. ovf=1: Num_Hex5=0x0E, Num_Hex4=0x11, Blanked=6'b001111, DP_in=0.
  3. Normal case:
     - Digits = BCD nibbles; Num_Hex4/5 are zero-extended.
     - DP_in bit dp_pos is set when dp_pos ≤ 5.
     - With blank_lz=1, blank every digit above the most significant nonzero digit, except digit 0 and any digit at or below dp_pos.
     - neg=1: Num_Hex5=0x10 and Blanked[5]=0, regardless of blanking.
- `load` while not ready: ignored, no effect.
- Inputs other than `load` are don't-care outside the accept cycle.

## Timing
- Reset values:
  - State IDLE, ready=1, done=0, overflow=0.
  - All Num_Hex = 0, Blanked=6'h3F, DP_in=0.
  - BCD accumulator and counter cleared.
- Latency: load accepted at edge k. Outputs and `done` update at edge k+WIDTH+1. `done` is high for exactly one cycle.
- ready=0 from edge k until edge k+WIDTH+1. It is 1 in the `done` cycle, so a back-to-back `load` is accepted during `done`.
- Display outputs hold their last values throughout CONVERT. No intermediate values are ever visible.
- Reset asserted mid-CONVERT or in FORMAT: the conversion is aborted and all outputs take their reset values at that edge. No `done` pulse is issued.
- Signed minimum (−2^(WIDTH−1)): the magnitude fits in WIDTH unsigned bits and must be handled without wrap.

## Structure
- Package `display_pkg`:
  - state enum.
  - Character constants: CHAR_MINUS=5'h10, CHAR_R=5'h11, CHAR_E=5'h0E.
  - Limits: MAX_UNSIGNED=999999, MAX_NEG=99999.
  - DP_NONE index constants.
- Sub-module `bcd_add3_shift` (combinational): takes the 24-bit BCD accumulator and the incoming bit, and returns the next accumulator. It is instantiated once.
- The top level holds the FSM, capture registers, counter and formatting/output registers.

## Test plan
- Reset, then load value=123456, blank_lz=0, dp_pos=7 with WIDTH=20 → `done` at edge k+21. Digits 5..0 = 1,2,3,4,5,6. Blanked=0. DP_in=0.
- Load 42 with blank_lz=1, dp_pos=2 → digits 0,0,0,0,4,2. Blanked=6'b111000. DP_in=6'b000100.
- SIGNED=1: load −305 (20'hFFECF) with blank_lz=1 → Num_Hex5=0x10. Digits 2..0 = 3,0,5. Blanked=6'b011000.
- Unsigned load of 1000000 → overflow=1, Num_Hex5=0x0E, Num_Hex4=0x11, Blanked=6'b001111.
- Back-to-back and collision:
  - A `load` during CONVERT is ignored, and the first result is unchanged.
  - A `load` in the `done` cycle is accepted; the second result arrives WIDTH+1 cycles later.
- Reset asserted 5 cycles into CONVERT → the next cycle shows reset values, ready=1 and no `done` pulse. A subsequent load of 0 displays a single "0" on digit 0 when blank_lz=1.

Source files
------------

// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the display_formatter block:
//   state_e      - controller states (IDLE / CONVERT / FORMAT)
//   CHAR_*       - non-digit codes understood by the seven-segment decoder
//   MAX_*        - largest magnitudes that fit on six digits
//   DP_NONE      - first dp_pos index meaning "no decimal point" (6 and 7)
//   BLANK_*      - Blanked patterns for the all-dark and "Er" displays
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FORMAT  = 2'd2
    } state_e;

    localparam logic [4:0] CHAR_MINUS = 5'h10;
    localparam logic [4:0] CHAR_R     = 5'h11;
    localparam logic [4:0] CHAR_E     = 5'h0E;

    localparam int unsigned MAX_UNSIGNED = 999999;
    // A negative number needs digit 5 for the '-', leaving five digits.
    localparam int unsigned MAX_NEG      = 99999;

    // dp_pos values 6 and 7 both mean "no point"; anything below DP_NONE is a digit index.
    localparam logic [2:0] DP_NONE = 3'd6;

    localparam logic [5:0] BLANK_ALL = 6'h3F;
    localparam logic [5:0] BLANK_OVF = 6'b001111;

endpackage

// File: rtl/bcd_add3_shift.sv
// ---------------------------------------------------------------------------
// bcd_add3_shift
// One combinational step of the shift-add-3 (double dabble) conversion.
//   bcd_i  [23:0]  current six-nibble BCD accumulator
//   bit_i          next binary bit, MSB first
//   bcd_o  [23:0]  accumulator after the add-3 correction and a left shift
// ---------------------------------------------------------------------------
module bcd_add3_shift (
    input  logic [23:0] bcd_i,
    input  logic        bit_i,
    output logic [23:0] bcd_o
);

    logic [19:0] adj_lo;
    logic [2:0]  adj_top;

    always_comb begin
        adj_lo = bcd_i[19:0];
        for (int i = 0; i < 5; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj_lo[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
        // The top nibble's MSB is shifted out, so only its low three bits are kept.
        // That drops a seventh decimal digit; the lower six stay exact (value mod 10^6).
        if (bcd_i[23:20] >= 4'd5) begin
            adj_top = bcd_i[22:20] + 3'd3;
        end else begin
            adj_top = bcd_i[22:20];
        end
        bcd_o = {adj_top, adj_lo, bit_i};
    end

endmodule

// File: rtl/display_formatter.sv
// ---------------------------------------------------------------------------
// display_formatter
// Converts a binary value to six display digits for the seven-segment stage.
// One bit is converted per clock; all display outputs update together in one cycle.
// Parameters: WIDTH (4..20) binary width, SIGNED (1 = two's complement value).
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   load, value             conversion request and operand
//   dp_pos, blank_lz,
//   display_en              formatting controls, captured with the load
//   ready                   idle; a load is accepted this cycle
//   done                    one-cycle pulse when new outputs are valid
//   overflow                last accepted value did not fit on the display
//   Num_Hex0..3             BCD digits 0..3 (digit 0 least significant)
//   Num_Hex4, Num_Hex5      5-bit digit codes (hex digit, '-', 'r')
//   Blanked, DP_in          per-digit blanking and decimal-point enables
//   dbg_state_o             controller state, for observation only
// Handshake: a load is taken on a rising edge where load=1 and ready=1. ready
// drops that edge and rises again with done, so a load held during the done
// cycle is accepted back-to-back. A load seen while ready=0 is dropped.
// ---------------------------------------------------------------------------
module display_formatter
    import display_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       dp_pos,
    input  logic             blank_lz,
    input  logic             display_en,
    output logic             ready,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       Num_Hex0,
    output logic [3:0]       Num_Hex1,
    output logic [3:0]       Num_Hex2,
    output logic [3:0]       Num_Hex3,
    output logic [4:0]       Num_Hex4,
    output logic [4:0]       Num_Hex5,
    output logic [5:0]       Blanked,
    output logic [5:0]       DP_in,
    output state_e           dbg_state_o
);

    localparam logic [4:0] CNT_INIT = 5'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] mag_q;
    logic [23:0]      bcd_q;
    logic [23:0]      bcd_d;
    logic [4:0]       cnt_q;
    logic             neg_q, ovf_q, blz_q, en_q;
    logic [2:0]       dp_q;

    logic             ready_q, done_q, overflow_q;
    logic [3:0]       hex0_q, hex1_q, hex2_q, hex3_q;
    logic [4:0]       hex4_q, hex5_q;
    logic [5:0]       blank_q, dpin_q;

    // Operand decode at the accept edge. Negating the signed minimum yields
    // 2^(WIDTH-1), which is correct when read as an unsigned WIDTH-bit number.
    logic             neg_in, ovf_in;
    logic [WIDTH-1:0] mag_in;
    logic [31:0]      mag_ext;

    assign neg_in  = SIGNED && value[WIDTH-1];
    assign mag_in  = neg_in ? (~value) + WIDTH'(1) : value;
    assign mag_ext = 32'(mag_in);
    assign ovf_in  = neg_in ? (mag_ext > MAX_NEG) : (mag_ext > MAX_UNSIGNED);

    bcd_add3_shift u_step (
        .bcd_i (bcd_q),
        .bit_i (mag_q[WIDTH-1]),
        .bcd_o (bcd_d)
    );

    // Display image built from the finished accumulator; only registered in FORMAT.
    logic [3:0] hex0_d, hex1_d, hex2_d, hex3_d;
    logic [4:0] hex4_d, hex5_d;
    logic [5:0] blank_d, dpin_d;
    logic       seen_nz;

    always_comb begin
        hex0_d  = bcd_q[3:0];
        hex1_d  = bcd_q[7:4];
        hex2_d  = bcd_q[11:8];
        hex3_d  = bcd_q[15:12];
        hex4_d  = {1'b0, bcd_q[19:16]};
        hex5_d  = {1'b0, bcd_q[23:20]};
        blank_d = '0;
        dpin_d  = '0;
        seen_nz = 1'b0;
        if (!en_q) begin
            blank_d = BLANK_ALL;
        end else if (ovf_q) begin
            hex5_d  = CHAR_E;
            hex4_d  = CHAR_R;
            blank_d = BLANK_OVF;
        end else begin
            if (dp_q < DP_NONE) begin
                dpin_d = 6'd1 << dp_q;
            end
            // Scan from the top: a digit is a leading zero until a nonzero digit is seen.
            // Digit 0 and digits at or below the point always stay lit.
            for (int i = 5; i >= 0; i--) begin
                if (bcd_q[4*i +: 4] != 4'd0) begin
                    seen_nz = 1'b1;
                end
                if (blz_q && !seen_nz && i != 0 && !(dp_q < DP_NONE && i <= int'(dp_q))) begin
                    blank_d[i] = 1'b1;
                end
            end
            if (neg_q) begin
                hex5_d     = CHAR_MINUS;
                blank_d[5] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            blz_q      <= 1'b0;
            en_q       <= 1'b0;
            dp_q       <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            hex0_q     <= '0;
            hex1_q     <= '0;
            hex2_q     <= '0;
            hex3_q     <= '0;
            hex4_q     <= '0;
            hex5_q     <= '0;
            blank_q    <= BLANK_ALL;
            dpin_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        mag_q   <= mag_in;
                        neg_q   <= neg_in;
                        ovf_q   <= ovf_in;
                        dp_q    <= dp_pos;
                        blz_q   <= blank_lz;
                        en_q    <= display_en;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        state_q <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_q << 1;
                    if (cnt_q == 5'd0) begin
                        state_q <= ST_FORMAT;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                ST_FORMAT: begin
                    hex0_q     <= hex0_d;
                    hex1_q     <= hex1_d;
                    hex2_q     <= hex2_d;
                    hex3_q     <= hex3_d;
                    hex4_q     <= hex4_d;
                    hex5_q     <= hex5_d;
                    blank_q    <= blank_d;
                    dpin_q     <= dpin_d;
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign Num_Hex0    = hex0_q;
    assign Num_Hex1    = hex1_q;
    assign Num_Hex2    = hex2_q;
    assign Num_Hex3    = hex3_q;
    assign Num_Hex4    = hex4_q;
    assign Num_Hex5    = hex5_q;
    assign Blanked     = blank_q;
    assign DP_in       = dpin_q;
    assign dbg_state_o = state_q;

endmodule
